// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
//   Shared definitions for the 5-stage core stall/flush controller:
//   stall-bus width and bit indices, FSM state encoding, and the stall-merge
//   priority function.
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  localparam int STALL_W     = 5;
  localparam int STALL_PC    = 0;
  localparam int STALL_IFID  = 1;
  localparam int STALL_IDEX  = 2;
  localparam int STALL_EXMEM = 3;
  localparam int STALL_MEMWB = 4;

  // Hold patterns: a stage stalls itself and everything upstream of it.
  localparam logic [STALL_W-1:0] HOLD_MEM  = 5'b11111;
  localparam logic [STALL_W-1:0] HOLD_EX   = 5'b01111;
  localparam logic [STALL_W-1:0] HOLD_ID   = 5'b00111;
  localparam logic [STALL_W-1:0] HOLD_IF   = 5'b00011;
  localparam logic [STALL_W-1:0] HOLD_NONE = 5'b00000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1
  } state_t;

  // The most downstream requesting stage wins; its hold pattern covers
  // every request from earlier stages.
  function automatic logic [STALL_W-1:0] merge_stall(
    input logic req_if,
    input logic req_id,
    input logic req_ex,
    input logic req_mem
  );
    if (req_mem)     return HOLD_MEM;
    else if (req_ex) return HOLD_EX;
    else if (req_id) return HOLD_ID;
    else if (req_if) return HOLD_IF;
    else             return HOLD_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all ones instead of wrapping.
//   Ports:
//     clk    clock
//     rst    asynchronous active-low reset (count -> 0)
//     inc    increment this cycle
//     clr    synchronous clear, takes priority over inc
//     count  current value
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      count <= '0;
    else if (clr)                  count <= '0;
    else if (inc && (count != '1)) count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Stall/flush scheduler for the IF/ID/EX/MEM/WB core. Merges per-stage stall
//   requests, sequences exception flushes (deferring them while MEM waits on
//   the bus), counts stalled cycles and runs a stall watchdog.
//   Ports:
//     clk, rst                clock; asynchronous active-low reset
//     stall_req_if/id/ex/mem  per-stage stall requests
//     exc_flag, exc_addr      exception from MEM and its handler address
//     perf_clear              synchronous clear of stall_cycles and timeout
//     stall[4:0]              hold: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//     flush, flush_pc         kill pipeline and redirect PC (flush_pc=0 if idle)
//     stall_cycles            saturating count of cycles with stall[PC]=1
//     timeout                 sticky watchdog flag
// -----------------------------------------------------------------------------
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int CNT_WIDTH     = 32,
  parameter int STALL_TIMEOUT = 1023  // must be >= 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_req_if,
  input  logic                  stall_req_id,
  input  logic                  stall_req_ex,
  input  logic                  stall_req_mem,
  input  logic                  exc_flag,
  input  logic [ADDR_WIDTH-1:0] exc_addr,
  input  logic                  perf_clear,
  output logic [STALL_W-1:0]    stall,
  output logic                  flush,
  output logic [ADDR_WIDTH-1:0] flush_pc,
  output logic [CNT_WIDTH-1:0]  stall_cycles,
  output logic                  timeout
);

  localparam int WD_W = $clog2(STALL_TIMEOUT + 1);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] exc_addr_q;
  logic                  latch_en;
  logic [WD_W-1:0]       wd_count;
  logic                  wd_hit;

  // State and deferred-exception address.
  // NOTE: every control register here has an async reset; the latched address
  // is cleared too so a reset mid-WAIT_MEM leaves nothing pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      exc_addr_q <= '0;
    end else begin
      state <= state_next;
      if (latch_en) exc_addr_q <= exc_addr;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    stall      = HOLD_NONE;
    flush      = 1'b0;
    flush_pc   = '0;
    latch_en   = 1'b0;

    unique case (state)
      RUN: begin
        if (exc_flag && !stall_req_mem) begin
          // Flush overrides every stall request this cycle.
          flush    = 1'b1;
          flush_pc = exc_addr;
        end else if (exc_flag) begin
          // MEM is mid-bus-access: freeze everything and flush once it lets go.
          stall      = HOLD_MEM;
          latch_en   = 1'b1;
          state_next = WAIT_MEM;
        end else begin
          stall = merge_stall(stall_req_if, stall_req_id, stall_req_ex, stall_req_mem);
        end
      end
      WAIT_MEM: begin
        // Further exceptions are ignored: the first one owns the flush.
        if (stall_req_mem) begin
          stall = HOLD_MEM;
        end else begin
          flush      = 1'b1;
          flush_pc   = exc_addr_q;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase

    // Outputs read as idle while reset is held, regardless of request inputs.
    if (!rst) begin
      stall      = HOLD_NONE;
      flush      = 1'b0;
      flush_pc   = '0;
      latch_en   = 1'b0;
      state_next = RUN;
    end
  end

  // Performance counter of stalled cycles.
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cycles (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall[STALL_PC]),
    .clr   (perf_clear),
    .count (stall_cycles)
  );

  // Watchdog: length of the current uninterrupted stall run.
  sat_counter #(.WIDTH(WD_W)) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall[STALL_PC]),
    .clr   (~stall[STALL_PC]),
    .count (wd_count)
  );

  // Fires on the edge that takes the run length to STALL_TIMEOUT, so timeout
  // becomes visible together with the counter reaching the limit.
  assign wd_hit = stall[STALL_PC] && (wd_count == WD_W'(STALL_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            timeout <= 1'b0;
    else if (perf_clear) timeout <= 1'b0;
    else if (wd_hit)     timeout <= 1'b1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//   Directed testbench for pipeline_ctrl (CNT_WIDTH=4, STALL_TIMEOUT=8).
//   Inputs change 1 time unit after a rising edge; outputs are compared a
//   further time unit later, well clear of either clock edge.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam int AW = 32;
  localparam int CW = 4;
  localparam int TO = 8;

  logic          clk;
  logic          rst;
  logic          stall_req_if, stall_req_id, stall_req_ex, stall_req_mem;
  logic          exc_flag;
  logic [AW-1:0] exc_addr;
  logic          perf_clear;
  logic [4:0]    stall;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [CW-1:0] stall_cycles;
  logic          timeout;

  int passed = 0;
  int total  = 0;

  pipeline_ctrl #(
    .ADDR_WIDTH   (AW),
    .CNT_WIDTH    (CW),
    .STALL_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req_if (stall_req_if),
    .stall_req_id (stall_req_id),
    .stall_req_ex (stall_req_ex),
    .stall_req_mem(stall_req_mem),
    .exc_flag     (exc_flag),
    .exc_addr     (exc_addr),
    .perf_clear   (perf_clear),
    .stall        (stall),
    .flush        (flush),
    .flush_pc     (flush_pc),
    .stall_cycles (stall_cycles),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall_req_if  = 1'b0;
    stall_req_id  = 1'b0;
    stall_req_ex  = 1'b0;
    stall_req_mem = 1'b0;
    exc_flag      = 1'b0;
    exc_addr      = '0;
    perf_clear    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    stall_req_mem = 1'b1;  // outputs must stay idle under reset anyway
    #3;
    total++; if (stall !== 5'b00000) $display("FAIL reset_stall: got %b want 00000", stall); else passed++;
    total++; if (flush !== 1'b0) $display("FAIL reset_flush: got %b want 0", flush); else passed++;
    total++; if (flush_pc !== 32'h0) $display("FAIL reset_flush_pc: got %h want 0", flush_pc); else passed++;
    total++; if (stall_cycles !== 4'h0) $display("FAIL reset_stall_cycles: got %h want 0", stall_cycles); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", timeout); else passed++;
    stall_req_mem = 1'b0;
    #9 rst = 1'b1;
    step();
    total++; if (stall !== 5'b00000 || flush !== 1'b0 || stall_cycles !== 4'h0)
      $display("FAIL post_reset_idle: got stall=%b flush=%b cnt=%h want 00000/0/0", stall, flush, stall_cycles);
    else passed++;
  endtask

  task automatic test_id_stall();
    stall_req_id = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (stall !== 5'b00111) $display("FAIL id_stall cyc%0d: got %b want 00111", i, stall); else passed++;
      step();
    end
    stall_req_id = 1'b0;
    #1;
    total++; if (stall !== 5'b00000) $display("FAIL id_release: got %b want 00000", stall); else passed++;
    total++; if (stall_cycles !== 4'd3) $display("FAIL id_stall_cycles: got %0d want 3", stall_cycles); else passed++;
    step();
  endtask

  task automatic test_priority();
    stall_req_if = 1'b1;
    stall_req_ex = 1'b1;
    #1;
    total++; if (stall !== 5'b01111) $display("FAIL prio_if_ex: got %b want 01111", stall); else passed++;
    stall_req_mem = 1'b1;
    #1;
    total++; if (stall !== 5'b11111) $display("FAIL prio_mem: got %b want 11111", stall); else passed++;
    stall_req_ex  = 1'b0;
    stall_req_mem = 1'b0;
    #1;
    total++; if (stall !== 5'b00011) $display("FAIL prio_if_only: got %b want 00011", stall); else passed++;
    clear_inputs();
    step();
  endtask

  task automatic test_flush_now();
    exc_flag     = 1'b1;
    exc_addr     = 32'hBFC0_0380;
    stall_req_ex = 1'b1;  // flush must override this request
    #1;
    total++; if (flush !== 1'b1) $display("FAIL flush_now: got %b want 1", flush); else passed++;
    total++; if (flush_pc !== 32'hBFC0_0380) $display("FAIL flush_now_pc: got %h want bfc00380", flush_pc); else passed++;
    total++; if (stall !== 5'b00000) $display("FAIL flush_now_stall: got %b want 00000", stall); else passed++;
    step();
    clear_inputs();
    #1;
    total++; if (flush !== 1'b0 || flush_pc !== 32'h0)
      $display("FAIL flush_now_after: got flush=%b pc=%h want 0/0", flush, flush_pc);
    else passed++;
    step();
  endtask

  task automatic test_flush_deferred();
    exc_flag      = 1'b1;
    exc_addr      = 32'h8000_0180;
    stall_req_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (stall !== 5'b11111 || flush !== 1'b0)
        $display("FAIL defer_hold cyc%0d: got stall=%b flush=%b want 11111/0", i, stall, flush);
      else passed++;
      step();
      exc_addr = 32'h0000_1234;  // second exception while waiting: ignored
    end
    exc_flag      = 1'b0;
    stall_req_mem = 1'b0;
    #1;
    total++; if (flush !== 1'b1) $display("FAIL defer_flush: got %b want 1", flush); else passed++;
    total++; if (flush_pc !== 32'h8000_0180) $display("FAIL defer_flush_pc: got %h want 80000180", flush_pc); else passed++;
    total++; if (stall !== 5'b00000) $display("FAIL defer_flush_stall: got %b want 00000", stall); else passed++;
    step();
    #1;
    total++; if (flush !== 1'b0) $display("FAIL defer_back_run: got flush=%b want 0", flush); else passed++;
    step();
  endtask

  task automatic test_watchdog();
    perf_clear = 1'b1;
    step();
    perf_clear = 1'b0;
    #1;
    total++; if (stall_cycles !== 4'd0 || timeout !== 1'b0)
      $display("FAIL wd_preclear: got cnt=%0d to=%b want 0/0", stall_cycles, timeout);
    else passed++;
    stall_req_ex = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++; if (timeout !== (i >= TO))
        $display("FAIL wd_timeout after %0d stalled: got %b want %b", i, timeout, (i >= TO));
      else passed++;
    end
    total++; if (stall_cycles !== 4'd10) $display("FAIL wd_stall_cycles: got %0d want 10", stall_cycles); else passed++;
    stall_req_ex = 1'b0;
    step();
    step();
    total++; if (timeout !== 1'b1) $display("FAIL wd_sticky: got %b want 1", timeout); else passed++;
    perf_clear = 1'b1;
    step();
    perf_clear = 1'b0;
    #1;
    total++; if (timeout !== 1'b0 || stall_cycles !== 4'd0)
      $display("FAIL wd_clear: got to=%b cnt=%0d want 0/0", timeout, stall_cycles);
    else passed++;
  endtask

  task automatic test_saturation();
    stall_req_ex = 1'b1;
    for (int i = 0; i < 20; i++) step();
    total++; if (stall_cycles !== 4'hF) $display("FAIL sat_cnt: got %h want f", stall_cycles); else passed++;
    stall_req_ex = 1'b0;
    step();
    total++; if (stall_cycles !== 4'hF) $display("FAIL sat_hold: got %h want f", stall_cycles); else passed++;
  endtask

  task automatic test_reset_in_wait();
    exc_flag      = 1'b1;
    exc_addr      = 32'hDEAD_BEEC;
    stall_req_mem = 1'b1;
    step();
    exc_flag = 1'b0;
    #1;
    total++; if (stall !== 5'b11111) $display("FAIL wait_hold: got %b want 11111", stall); else passed++;
    rst = 1'b0;
    #1;
    total++; if (stall !== 5'b00000 || stall_cycles !== 4'h0 || timeout !== 1'b0)
      $display("FAIL async_clear: got stall=%b cnt=%h to=%b want 00000/0/0", stall, stall_cycles, timeout);
    else passed++;
    rst = 1'b1;
    stall_req_mem = 1'b0;
    #1;
    total++; if (flush !== 1'b0 || flush_pc !== 32'h0)
      $display("FAIL no_flush_after_reset: got flush=%b pc=%h want 0/0", flush, flush_pc);
    else passed++;
    step();
    total++; if (flush !== 1'b0 || stall !== 5'b00000)
      $display("FAIL no_flush_next: got flush=%b stall=%b want 0/00000", flush, stall);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_id_stall();
    test_priority();
    test_flush_now();
    test_flush_deferred();
    test_watchdog();
    test_saturation();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
